// File: rtl/count_dir_decoder.sv
// rtl/count_dir_decoder.sv - recovers up/down direction from an observed counter bus
// Optional stall detector on long holds while locked: define COUNT_DEC_STALL_DET_EN.
module count_dir_decoder #(
  parameter int WIDTH      = 4,
  parameter int LOCK_CNT   = 3,
  parameter int ERR_W      = 8,
  parameter int HOLD_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] count_in,
  output logic             mode_out,
  output logic             locked,
  output logic             dir_change,
  output logic             rst_seen,
  output logic             step_err,
`ifdef COUNT_DEC_STALL_DET_EN
  output logic             stall,
`endif
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_V   = 4'(LOCK_CNT);
  localparam logic [3:0]       RUN_ONE  = 4'd1;
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [WIDTH-1:0] DIFF_ONE = WIDTH'(1);

  if (WIDTH < 2 || LOCK_CNT < 1 || LOCK_CNT > 15 || HOLD_LIMIT < 1) begin : g_param_check
    $error("count_dir_decoder: illegal parameter value");
  end

  state_t           state, state_d;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] diff;
  logic [3:0]       run_cnt, run_d, run_acq;
  logic             cand_dir, cand_d;
  logic             mode_d, locked_d, dir_change_d, rst_seen_d, step_err_d;
  logic [ERR_W-1:0] err_d;
  logic             is_up, is_down, is_step, is_jump, is_zero, step_dir;
  logic             stall_hit;

  // Modular difference makes the wrap steps (max->0, 0->max) ordinary steps.
  assign diff     = count_in - prev;
  assign is_up    = (diff == DIFF_ONE);
  assign is_down  = &diff;
  assign is_step  = is_up | is_down;
  assign is_jump  = !is_step && (diff != '0);
  assign is_zero  = (count_in == '0);
  assign step_dir = is_down;

`ifdef COUNT_DEC_STALL_DET_EN
  localparam int              HOLD_W    = $clog2(HOLD_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIMIT - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic              is_hold;

  assign is_hold = (diff == '0);

  always_comb begin
    hold_d    = hold_cnt;
    stall_hit = 1'b0;
    if (valid_in) begin
      hold_d = '0;
      if (state == S_LOCKED && is_hold) begin
        if (hold_cnt == HOLD_LAST) stall_hit = 1'b1;
        else                       hold_d    = hold_cnt + HOLD_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
      stall    <= 1'b0;
    end else begin
      hold_cnt <= hold_d;
      stall    <= stall_hit;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // A step that disagrees with the candidate restarts the run at one.
  always_comb begin
    run_acq = run_cnt;
    if (is_step) begin
      if (run_cnt == '0 || step_dir == cand_dir) run_acq = run_cnt + RUN_ONE;
      else                                       run_acq = RUN_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (valid_in) begin
      unique case (state)
        S_IDLE:   state_d = S_ACQ;
        S_ACQ:    if (is_step && run_acq >= LOCK_V) state_d = S_LOCKED;
        S_LOCKED: if (is_jump || stall_hit) state_d = S_ACQ;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mode_d       = mode_out;
    locked_d     = locked;
    run_d        = run_cnt;
    cand_d       = cand_dir;
    err_d        = err_count;
    dir_change_d = 1'b0;
    rst_seen_d   = 1'b0;
    step_err_d   = 1'b0;
    if (valid_in) begin
      unique case (state)
        S_IDLE: run_d = '0;
        S_ACQ: begin
          if (is_step) begin
            cand_d = step_dir;
            run_d  = run_acq;
            if (run_acq >= LOCK_V) begin
              mode_d   = step_dir;
              locked_d = 1'b1;
            end
          end else if (is_jump) begin
            run_d      = '0;
            rst_seen_d = is_zero;
          end
        end
        S_LOCKED: begin
          if (is_step && step_dir != mode_out) begin
            mode_d       = step_dir;
            dir_change_d = 1'b1;
          end
          if (is_jump || stall_hit) begin
            locked_d = 1'b0;
            run_d    = '0;
          end
          // A jump to zero is a counter reset, not a fault.
          if (is_jump) begin
            if (is_zero) begin
              rst_seen_d = 1'b1;
            end else begin
              step_err_d = 1'b1;
              if (err_count != '1) err_d = err_count + ERR_ONE;
            end
          end
        end
        default: locked_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev       <= '0;
      run_cnt    <= '0;
      cand_dir   <= 1'b0;
      mode_out   <= 1'b0;
      locked     <= 1'b0;
      dir_change <= 1'b0;
      rst_seen   <= 1'b0;
      step_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      if (valid_in) prev <= count_in;
      run_cnt    <= run_d;
      cand_dir   <= cand_d;
      mode_out   <= mode_d;
      locked     <= locked_d;
      dir_change <= dir_change_d;
      rst_seen   <= rst_seen_d;
      step_err   <= step_err_d;
      err_count  <= err_d;
    end
  end

endmodule

// File: doc/count_dir_decoder.md
Name: count_dir_decoder

Overview:
- Observes the count bus of an up/down counter and recovers the counter's direction (mode) from successive samples; the inverse path of the counter's mode → count mapping.
- Locks after LOCK_CNT consistent steps, tracks direction changes, flags counter resets and illegal jumps, and keeps a saturating error count.
- Sits beside any up/down counter instance as an in-system monitor, or as the checker end in counter benches.

Parameters:
- WIDTH, 4, width of observed count bus; legal range >= 2.
- LOCK_CNT, 3, consecutive same-direction steps required to lock; legal range 1..15.
- ERR_W, 8, width of err_count.
- HOLD_LIMIT, 16, consecutive hold samples allowed while locked; used only with the optional feature.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- valid_in  input  1  count_in is sampled on this cycle.
- count_in  input  WIDTH  observed counter value.
- mode_out  output  1  decoded direction: 0 = up, 1 = down. Matches the counter's mode encoding.
- locked  output  1  mode_out is trustworthy.
- dir_change  output  1  one-cycle pulse: locked direction flipped.
- rst_seen  output  1  one-cycle pulse: counter reset (jump to 0) detected.
- step_err  output  1  one-cycle pulse: illegal jump detected while locked.
- err_count  output  ERR_W  saturating count of step_err events.

Behaviour:
- Reset (rst == 0 at posedge): state = IDLE; prev = 0; run_cnt = 0; cand_dir = 0.
  - All outputs go to 0: mode_out, locked, dir_change, rst_seen, step_err, err_count.
  - Reset mid-operation discards lock and err_count.
- All outputs are registered and reflect the sample taken on the previous valid cycle (latency 1).
- When valid_in == 0: no state change; pulse outputs are 0.
- Step classification uses diff = (count_in - prev) mod 2^WIDTH:
  - diff == 1 → UP. Covers wrap, e.g. 15 → 0 at WIDTH = 4.
  - diff == 2^WIDTH - 1 → DOWN. Covers wrap, e.g. 0 → 15.
  - diff == 0 → HOLD.
  - Otherwise → JUMP.
  - ZERO_JUMP = JUMP with count_in == 0.
- prev <= count_in on every valid sample.
- FSM states: IDLE, ACQ, LOCKED.
- IDLE:
  - On valid: capture prev, go to ACQ, run_cnt = 0.
- ACQ (locked = 0):
  - UP or DOWN equal to cand_dir, or run_cnt == 0: cand_dir = dir; run_cnt += 1.
  - If run_cnt reaches LOCK_CNT: go to LOCKED, mode_out = cand_dir, locked = 1.
  - Opposite step: cand_dir = new dir; run_cnt = 1.
  - HOLD: no change.
  - JUMP: run_cnt = 0. No error is raised in ACQ.
  - ZERO_JUMP: additionally pulse rst_seen.
- LOCKED:
  - Step equal to mode_out: stay.
  - Opposite step: mode_out flips the same cycle; dir_change = 1; stay locked.
  - HOLD: stay.
  - ZERO_JUMP: rst_seen = 1, no error; go to ACQ; locked = 0; run_cnt = 0.
  - Other JUMP: step_err = 1; err_count += 1, saturating at 2^ERR_W - 1; go to ACQ; locked = 0; run_cnt = 0.
- Simultaneous events: only one class exists per sample, so no priority conflict arises. ZERO_JUMP takes precedence over JUMP.
- Value 0 reached by a legal step (1 → 0 down, or 15 → 0 up) is a step, not ZERO_JUMP.

Optional Feature:
- Macro: COUNT_DEC_STALL_DET_EN.
- Defined:
  - Adds a hold counter, cleared on any non-HOLD sample and in ACQ/IDLE.
  - In LOCKED, the HOLD_LIMIT-th consecutive HOLD sample drops lock (go to ACQ, run_cnt = 0) and pulses an extra output port stall (1 bit, reset 0).
- Undefined: no stall port, no hold counter; HOLD never affects lock.

Test Plan:
- Lock up:
  - Reset (rst = 0 for 2 cycles), then valid samples 0,1,2,3.
  - Expected: locked = 1 and mode_out = 0 one cycle after sample 3; err_count = 0.
- Wrap both directions:
  - Locked up, samples 14,15,0,1: stays locked, no pulses.
  - Then samples 0,15,14: dir_change pulses once at the 1 → 0 step, mode_out = 1; the 0 → 15 wrap keeps lock.
- Counter reset:
  - Locked up at 9, sample 0.
  - Expected: rst_seen pulse, step_err = 0, locked = 0.
  - Then 1,2,3: relock, mode_out = 0.
- Illegal jump:
  - Locked down at 7, sample 12.
  - Expected: step_err pulse, err_count = 1, locked = 0.
  - Repeat the jump 300 times with ERR_W = 8: err_count saturates at 255.
- Valid gating and hold:
  - Locked up at 4, valid_in = 0 for 5 cycles with count_in garbage, then sample 5: no pulses, still locked.
  - Samples 5,5,5: still locked. With COUNT_DEC_STALL_DET_EN and HOLD_LIMIT = 3, stall pulses on the third hold and locked = 0.
- Reset mid-operation:
  - Locked with err_count = 2, rst = 0 for one cycle.
  - Expected: all outputs 0 next cycle; the next sample returns the FSM to ACQ.
